// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared combinational ALU.
// Latency: accept -> resp_valid two cycles later (one cycle for rejected opcodes with ALU_ARB_OPCHECK_EN).
// Backpressure: single operation in flight; resp_ready low holds the response and blocks all grants.
// Optional feature macro: ALU_ARB_OPCHECK_EN (rejects illegal control codes without using the ALU).
module alu_arbiter #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [3:0]  req0_control,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [3:0]  req1_control,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_result,
  output logic        resp_zero,
  output logic        resp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_control,
  input  logic [15:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_served;
  logic        grant_id;
  logic        any_req;
  logic        accept;
  logic        op_legal;
  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic [3:0]  sel_control;

  // Round-robin choice: on contention favour the requester not served last.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_served;
    end else begin
      grant_id = req1_valid;
    end
    sel_a       = grant_id ? req1_a       : req0_a;
    sel_b       = grant_id ? req1_b       : req0_b;
    sel_control = grant_id ? req1_control : req0_control;
  end

`ifdef ALU_ARB_OPCHECK_EN
  // Only the six implemented ALU codes are forwarded; anything else is answered locally.
  always_comb begin
    case (sel_control)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101: op_legal = 1'b1;
      default:                                             op_legal = 1'b0;
    endcase
  end
`else
  assign op_legal = 1'b1;
`endif

  assign resp_valid = (state == RESP);

  // Next-state and grant decode; grants only from IDLE and never while reset is high.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && any_req) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = op_legal ? ISSUE : RESP;
        end
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch, response capture and round-robin pointer.
  // The alu_* registers double as the operand latch, so they only move on a legal accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_id     <= 1'b0;
      resp_result <= 16'h0000;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_control <= 4'h0;
      last_served <= ~FIRST_PRIO;
    end else begin
      if (accept) begin
        resp_id <= grant_id;
        if (op_legal) begin
          alu_a       <= sel_a;
          alu_b       <= sel_b;
          alu_control <= sel_control;
        end else begin
          resp_result <= 16'h0000;
          resp_zero   <= 1'b1;
          resp_err    <= 1'b1;
        end
      end
      if (state == ISSUE) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
        resp_err    <= 1'b0;
      end
      if (state == RESP && resp_ready) begin
        last_served <= resp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus a randomized transaction-level scoreboard run.
// Provides the shared combinational ALU externally.
// Summary line reports comparison count and error count.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_control, req1_control;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [15:0] resp_result;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [15:0] alu_result;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.FIRST_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_control(req0_control),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_control(req1_control),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Behaviour of the shared ALU (undefined codes give a recognisable pattern).
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    case (c)
      4'b0000: return {8'h00, a & b};
      4'b0001: return {8'h00, a | b};
      4'b0010: return {8'h00, a} + {8'h00, b};
      4'b0110: return {8'h00, a} - {8'h00, b};
      4'b1100: return {8'h00, ~(a | b)};
      4'b1101: return {8'h00, a} * {8'h00, b};
      default: return {c, 4'h0, a ^ b};
    endcase
  endfunction

  function automatic bit code_legal(input logic [3:0] c);
    return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0010) ||
           (c == 4'b0110) || (c == 4'b1100) || (c == 4'b1101);
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_control);
  assign alu_zero   = (alu_result == 16'h0000);

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
    req0_a = 8'h11; req0_b = 8'h22; req0_control = 4'b0010;
    req1_a = 8'h33; req1_b = 8'h44; req1_control = 4'b0001;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({resp_valid, resp_id, resp_result, resp_zero, resp_err, alu_a, alu_b, alu_control} !== 39'h0) begin
      errors++; $display("FAIL reset_outputs got v%b id%b r%h z%b e%b a%h b%h c%h want all zero",
                         resp_valid, resp_id, resp_result, resp_zero, resp_err, alu_a, alu_b, alu_control);
    end
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
  endtask

  task automatic test_single_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                                input logic [15:0] exp_res, input logic exp_zero, input string nm);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_control = c; resp_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL %s_grant got %b want 10", nm, {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({resp_valid, req0_ready, alu_a, alu_b, alu_control} !== {2'b00, a, b, c}) begin
      errors++; $display("FAIL %s_issue got v%b rdy%b a%h b%h c%h want v0 rdy0 a%h b%h c%h",
                         nm, resp_valid, req0_ready, alu_a, alu_b, alu_control, a, b, c);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_id, resp_result, resp_zero, resp_err} !== {2'b10, exp_res, exp_zero, 1'b0}) begin
      errors++; $display("FAIL %s_resp got v%b id%b r%h z%b e%b want v1 id0 r%h z%b e0",
                         nm, resp_valid, resp_id, resp_result, resp_zero, resp_err, exp_res, exp_zero);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL %s_done got resp_valid %b want 0", nm, resp_valid);
    end
  endtask

  task automatic test_alternate();
    logic exp0, exp1;
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    req0_control = 4'b0010; req1_control = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp0 = (i % 3 == 0) && ((i / 3) % 2 == 0);
      exp1 = (i % 3 == 0) && ((i / 3) % 2 == 1);
      checks++;
      if ({req0_ready, req1_ready} !== {exp0, exp1}) begin
        errors++; $display("FAIL alternate_cycle%0d got %b want %b", i, {req0_ready, req1_ready}, {exp0, exp1});
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'hFF; req1_control = 4'b1101; resp_ready = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_grant got %b want 01", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b1; req1_a = 8'h01; req1_control = 4'b0000;
    #1;
    checks++;
    if ({resp_valid, req0_ready, req1_ready} !== 3'b000) begin
      errors++; $display("FAIL bp_issue got v%b rdy%b%b want 000", resp_valid, req0_ready, req1_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({resp_valid, resp_id, resp_result, resp_zero, req0_ready, req1_ready} !== {2'b11, 16'hFE01, 3'b000}) begin
        errors++; $display("FAIL bp_hold%0d got v%b id%b r%h z%b rdy%b%b want v1 id1 rFE01 z0 rdy00",
                           i, resp_valid, resp_id, resp_result, resp_zero, req0_ready, req1_ready);
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    #1;
    checks++;
    if ({resp_valid, resp_result} !== {1'b1, 16'hFE01}) begin
      errors++; $display("FAIL bp_release got v%b r%h want v1 rFE01", resp_valid, resp_result);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_done got resp_valid %b want 0", resp_valid);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] passthru;
    passthru = alu_fn(8'h03, 8'h09, 4'b0111);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h09; req0_control = 4'b0111; resp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_grant got %b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
`ifdef ALU_ARB_OPCHECK_EN
    checks++;
    if ({resp_valid, resp_err, resp_result, resp_zero, alu_control, alu_a} !== {2'b11, 16'h0000, 1'b1, 4'b0110, 8'h05}) begin
      errors++; $display("FAIL illegal_resp got v%b e%b r%h z%b c%h a%h want v1 e1 r0000 z1 c6 a05",
                         resp_valid, resp_err, resp_result, resp_zero, alu_control, alu_a);
    end
`else
    checks++;
    if ({resp_valid, alu_control} !== {1'b0, 4'b0111}) begin
      errors++; $display("FAIL illegal_issue got v%b c%h want v0 c7", resp_valid, alu_control);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_err, resp_result} !== {2'b10, passthru}) begin
      errors++; $display("FAIL illegal_resp got v%b e%b r%h want v1 e0 r%h", resp_valid, resp_err, resp_result, passthru);
    end
`endif
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_done got resp_valid %b want 0", resp_valid);
    end
  endtask

  task automatic test_reset_issue();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'h21; req0_b = 8'h13; req0_control = 4'b0001; resp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rstissue_grant got %b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; reset = 1'b1;
    #1;
    checks++;
    if ({alu_a, alu_control, req0_ready, req1_ready} !== {8'h21, 4'b0001, 2'b00}) begin
      errors++; $display("FAIL rstissue_inflight got a%h c%h rdy%b%b want a21 c1 rdy00",
                         alu_a, alu_control, req0_ready, req1_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_id, resp_result, resp_zero, resp_err, alu_a, alu_b, alu_control, req1_ready} !== 40'h0) begin
      errors++; $display("FAIL rstissue_outputs got v%b id%b r%h z%b e%b a%h b%h c%h rdy%b want all zero",
                         resp_valid, resp_id, resp_result, resp_zero, resp_err, alu_a, alu_b, alu_control, req1_ready);
    end
    reset = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL rstissue_noresp%0d got resp_valid %b want 0", i, resp_valid);
      end
    end
  endtask

  // Transaction-level model: one job in flight, round-robin on contention, fixed response latency.
  task automatic test_random();
    logic [3:0]  codes [8];
    bit          m_busy, m_last, m_id, m_zero, m_err, g, v0, v1, exp0, exp1, exp_rv;
    int          m_acc, m_lat;
    logic [15:0] m_res;
    logic [7:0]  a, b;
    logic [3:0]  c;
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010; codes[3] = 4'b0110;
    codes[4] = 4'b1100; codes[5] = 4'b1101; codes[6] = 4'b0111; codes[7] = 4'b1111;
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_busy = 1'b0; m_last = 1'b1; m_acc = 0; m_lat = 2; m_id = 1'b0; m_res = '0; m_zero = 1'b0; m_err = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) @(negedge clk);
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      req0_valid = v0; req1_valid = v1;
      req0_a = 8'($urandom); req0_b = 8'($urandom); req0_control = codes[$urandom_range(0, 7)];
      req1_a = 8'($urandom); req1_b = 8'($urandom); req1_control = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) begin
        req0_b = req0_a;
        req0_control = 4'b0110;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g      = (v0 && v1) ? ~m_last : v1;
      exp0   = !m_busy && (v0 || v1) && !g;
      exp1   = !m_busy && (v0 || v1) && g;
      exp_rv = m_busy && (cyc >= m_acc + m_lat);
      checks++;
      if ({req0_ready, req1_ready, resp_valid} !== {exp0, exp1, exp_rv}) begin
        errors++; $display("FAIL rand_handshake cyc%0d got rdy%b%b v%b want rdy%b%b v%b",
                           cyc, req0_ready, req1_ready, resp_valid, exp0, exp1, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if ({resp_id, resp_result, resp_zero, resp_err} !== {m_id, m_res, m_zero, m_err}) begin
          errors++; $display("FAIL rand_resp cyc%0d got id%b r%h z%b e%b want id%b r%h z%b e%b",
                             cyc, resp_id, resp_result, resp_zero, resp_err, m_id, m_res, m_zero, m_err);
        end
        if (resp_ready) begin
          m_busy = 1'b0;
          m_last = m_id;
        end
      end else if (!m_busy && (v0 || v1)) begin
        a = g ? req1_a : req0_a;
        b = g ? req1_b : req0_b;
        c = g ? req1_control : req0_control;
        m_busy = 1'b1; m_acc = cyc; m_id = g;
`ifdef ALU_ARB_OPCHECK_EN
        if (!code_legal(c)) begin
          m_lat = 1; m_res = 16'h0000; m_zero = 1'b1; m_err = 1'b1;
        end else begin
          m_lat = 2; m_res = alu_fn(a, b, c); m_zero = (m_res == 16'h0000); m_err = 1'b0;
        end
`else
        m_lat = 2; m_res = alu_fn(a, b, c); m_zero = (m_res == 16'h0000); m_err = 1'b0;
`endif
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_op(8'h12, 8'h34, 4'b0010, 16'h0046, 1'b0, "single_add");
    test_alternate();
    test_backpressure();
    test_single_op(8'h05, 8'h05, 4'b0110, 16'h0000, 1'b1, "sub_zero");
    test_illegal();
    test_reset_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIRST_PRIO, 0, requester favoured by round-robin immediately after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  requester N's operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  8 each  operands.
REQ-007 req0_control / req1_control  input  4 each  ALU control code.
REQ-008 resp_valid  output  1  response available.
REQ-009 resp_ready  input  1  response consumer accepts.
REQ-010 resp_id  output  1  requester that owns the response.
REQ-011 resp_result  output  16  ALU result.
REQ-012 resp_zero  output  1  ALU zero flag.
REQ-013 resp_err  output  1  illegal control code (see Configuration).
REQ-014 alu_a, alu_b  output  8 each  operands driven to the shared ALU.
REQ-015 alu_control  output  4  control code driven to the shared ALU.
REQ-016 alu_result  input  16; alu_zero  input  1  combinational ALU outputs.

Function
REQ-017 FSM states IDLE, ISSUE, RESP; exactly one operation in flight.
REQ-018 IDLE: if any reqN_valid, grant one requester; if both, grant the one not served last (FIRST_PRIO before any grant).
REQ-019 reqN_ready is combinational, high only in IDLE for the granted requester, at most one high per cycle.
REQ-020 On valid&ready: latch a, b, control and id into registers; IDLE -> ISSUE next edge.
REQ-021 ISSUE: alu_a/alu_b/alu_control driven from latched registers; alu_result/alu_zero captured into response registers at end of cycle; ISSUE -> RESP.
REQ-022 alu_a/alu_b/alu_control are registered and hold last issued values outside ISSUE (no toggling).
REQ-023 RESP: resp_valid=1; resp_id/result/zero/err stable until resp_valid&resp_ready; then last-served <= resp_id, RESP -> IDLE.
REQ-024 Latency: accept at edge T -> resp_valid high from edge T+2; minimum accept-to-accept interval 3 cycles.
REQ-025 Backpressure: resp_ready low holds RESP indefinitely; no reqN_ready asserted meanwhile.
REQ-026 Requester fields ignored except in the accept cycle; dropping valid before accept withdraws the request without side effect.
REQ-027 Round-robin pointer updates only on response completion, never on idle cycles.

Reset
REQ-028 reset forces IDLE; resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, resp_err=0, alu_a=0, alu_b=0, alu_control=0, last-served = ~FIRST_PRIO.
REQ-029 reset in ISSUE or RESP discards the in-flight operation; no response produced.
REQ-030 reqN_ready=0 during any cycle with reset high.

Configuration
REQ-031 Macro ALU_ARB_OPCHECK_EN.
REQ-032 Defined: legal codes 0000,0001,0010,0110,1100,1101; illegal code skips ISSUE (IDLE -> RESP, latency 1), alu_* not updated, resp_result=0, resp_zero=1, resp_err=1.
REQ-033 Undefined: control passed through unchecked, all operations go through ISSUE, resp_err constant 0.

Verification
REQ-034 Single req0 a=8'h12 b=8'h34 control=0010 -> req0_ready 1 cycle, resp_valid 2 cycles later, resp_id=0, resp_result=16'h0046, resp_zero=0.
REQ-035 req0 and req1 valid continuously after reset, FIRST_PRIO=0, resp_ready=1 -> grants alternate 0,1,0,1; one accept every 3 cycles.
REQ-036 req1 a=8'hFF b=8'hFF control=1101, resp_ready low 5 cycles -> RESP held, result 16'hFE01 stable, no reqN_ready until release.
REQ-037 req0 a=8'h05 b=8'h05 control=0110 -> resp_result=0, resp_zero=1, resp_err=0.
REQ-038 With ALU_ARB_OPCHECK_EN, control=0111 -> resp_valid 1 cycle after accept, resp_err=1, resp_result=0, alu_control unchanged; without macro resp_err=0.
REQ-039 reset asserted during ISSUE -> next cycle IDLE, resp_valid never asserts for that operation, all outputs at REQ-028 values.
